// File: rtl/disp_arbiter_if.sv
// Request/data/grant bundle between the display sources and disp_arbiter.
interface disp_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
);
  logic [N_REQ-1:0]       req;
  logic [16*N_REQ-1:0]    data;
  logic [N_REQ-1:0]       grant;
  logic [IDX_W-1:0]       owner;
  logic [15:0]            disp_data;
  logic                   disp_valid;

  // Source side drives requests/data and observes the arbitration result.
  modport master (
    output req, data,
    input  grant, owner, disp_data, disp_valid
  );

  // Arbiter side.
  modport slave (
    input  req, data,
    output grant, owner, disp_data, disp_valid
  );
endinterface

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing one 4-digit hex display between N_REQ sources,
// with a minimum on-screen hold time per owner once someone else is waiting.
module disp_arbiter #(
  parameter int N_REQ      = 4,
  parameter int HOLD_TICKS = 1000,
  parameter int IDX_W      = 2
) (
  input  logic            clk,
  input  logic            rst,
  disp_arbiter_if.slave   bus
);

  localparam int                CNT_W     = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam int unsigned       NREQ_U    = N_REQ;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        disp_data_q, disp_data_d;
  logic               disp_valid_q, disp_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               expired_q, expired_d;

  logic [N_REQ-1:0]   pending;
  logic [IDX_W-1:0]   winner;

  // First asserted request scanning base+1, base+2, ... modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] base);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = base;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      idx = (32'(base) + k) % NREQ_U;
      if (!found && r[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Next-state logic: grant from IDLE, then drop / timed switch / keep in HOLD.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    cnt_d        = cnt_q;
    expired_d    = expired_q;
    pending      = bus.req & ~grant_q;
    winner       = '0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          winner          = rr_pick(bus.req, ptr_q);
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          ptr_d           = winner;
          disp_data_d     = bus.data[16*winner +: 16];
          disp_valid_d    = 1'b1;
          cnt_d           = '0;
          expired_d       = 1'b0;
          state_d         = HOLD;
        end
      end

      HOLD: begin
        disp_data_d = bus.data[16*owner_q +: 16];
        // Expiry is flagged on the edge the counter reaches HOLD_TICKS-1,
        // so a switch lands exactly HOLD_TICKS cycles after the grant.
        if (cnt_q == HOLD_LAST) begin
          expired_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          expired_d = (cnt_d == HOLD_LAST);
        end

        if (!bus.req[owner_q]) begin
          grant_d      = '0;
          disp_valid_d = 1'b0;
          disp_data_d  = disp_data_q;
          ptr_d        = owner_q;
          state_d      = IDLE;
        end else if (expired_q && (|pending)) begin
          winner          = rr_pick(pending, owner_q);
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          ptr_d           = winner;
          disp_data_d     = bus.data[16*winner +: 16];
          cnt_d           = '0;
          expired_d       = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset leaves requester 0 with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      ptr_q        <= IDX_W'(N_REQ - 1);
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      cnt_q        <= '0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      cnt_q        <= cnt_d;
      expired_q    <= expired_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owner      = owner_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with N_REQ=4, HOLD_TICKS=4.
module tb_disp_arbiter;

  localparam int N_REQ      = 4;
  localparam int HOLD_TICKS = 4;
  localparam int IDX_W      = 2;

  logic clk;
  logic rst;

  int n_cmp;
  int n_fail;

  logic [15:0] slice_v [N_REQ];

  disp_arbiter_if #(.N_REQ(N_REQ), .IDX_W(IDX_W)) bus ();

  disp_arbiter #(
    .N_REQ      (N_REQ),
    .HOLD_TICKS (HOLD_TICKS),
    .IDX_W      (IDX_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [15:0] v);
    slice_v[i]            = v;
    bus.data[16*i +: 16]  = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int own, input logic valid);
    logic [3:0] g;
    g = valid ? (4'b0001 << own) : 4'b0000;
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".valid"}, 32'(bus.disp_valid), 32'(valid));
    if (valid) begin
      chk({tag, ".owner"}, 32'(bus.owner), 32'(own));
      chk({tag, ".data"},  32'(bus.disp_data), 32'(slice_v[own]));
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.data = '0;
    set_slice(0, 16'hA000);
    set_slice(1, 16'hB111);
    set_slice(2, 16'hC222);
    set_slice(3, 16'hD333);

    // 1. Reset with all requests high, then first grant to requester 0.
    step();
    step();
    chk("rst.grant", 32'(bus.grant), 32'h0);
    chk("rst.valid", 32'(bus.disp_valid), 32'h0);
    chk("rst.data",  32'(bus.disp_data), 32'h0);
    chk("rst.owner", 32'(bus.owner), 32'h0);
    rst = 1'b0;
    step();
    chk_out("first", 0, 1'b1);

    // Owner drops: blank, data keeps last value.
    bus.req = 4'b0000;
    step();
    chk("drop0.grant", 32'(bus.grant), 32'h0);
    chk("drop0.valid", 32'(bus.disp_valid), 32'h0);
    chk("drop0.data",  32'(bus.disp_data), 32'hA000);

    // 2. Single source with live data tracking.
    bus.req = 4'b0010;
    set_slice(1, 16'hC1AC);
    step();
    chk_out("single", 1, 1'b1);
    set_slice(1, 16'h1234);
    step();
    chk("single.track", 32'(bus.disp_data), 32'h1234);
    set_slice(3, 16'hFFFF);
    for (int i = 0; i < 10; i++) step();
    chk_out("single.long", 1, 1'b1);
    bus.req = 4'b0000;
    step();
    chk("single.end", 32'(bus.grant), 32'h0);

    // 3. Two sources from a fresh reset: 0 and 2 alternate every 4 cycles.
    rst = 1'b1;
    step();
    chk("rst2.valid", 32'(bus.disp_valid), 32'h0);
    rst     = 1'b0;
    bus.req = 4'b0101;
    for (int i = 0; i < 16; i++) begin
      step();
      chk_out("alt", ((i / 4) % 2 == 0) ? 0 : 2, 1'b1);
    end

    // 4. Owner drop mid-hold while requester 1 waits.
    bus.req = 4'b0000;
    step();
    chk("idle4.grant", 32'(bus.grant), 32'h0);
    bus.req = 4'b0001;
    step();
    chk_out("own0", 0, 1'b1);
    bus.req = 4'b0011;
    step();
    step();
    bus.req = 4'b0010;
    step();
    chk("midhold.grant", 32'(bus.grant), 32'h0);
    chk("midhold.valid", 32'(bus.disp_valid), 32'h0);
    step();
    chk_out("midhold.next", 1, 1'b1);

    // 5. Full round robin: owner 1 finishes its slot, then 2,3,0,1,...
    bus.req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_out("rr", (1 + (i + 1) / 4) % 4, 1'b1);
    end

    // 6. Reset while owner is 2; pointer returns so requester 0 goes first.
    rst = 1'b1;
    step();
    chk("rst6.grant", 32'(bus.grant), 32'h0);
    chk("rst6.valid", 32'(bus.disp_valid), 32'h0);
    chk("rst6.owner", 32'(bus.owner), 32'h0);
    chk("rst6.data",  32'(bus.disp_data), 32'h0);
    rst = 1'b0;
    step();
    chk_out("rst6.first", 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares the single 4-digit hex display between up to N_REQ independent 16-bit data sources.
- Requesters raise req; the arbiter grants one at a time in round-robin order, enforcing a minimum on-screen hold time per owner.
- Drives the display driver's 16-bit data input plus a valid flag; when valid is low the display is blanked.
- Runs in the display clock domain (after clk_div).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_TICKS, 1000, minimum clk cycles an owner keeps the display once another requester is waiting (>=1).
- IDX_W, 2, owner index width; must equal clog2(N_REQ).

Ports:
- clk  in  1  display-domain clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  request per source; level-sensitive, held while the source wants the display.
- data  in  16*N_REQ  flattened source data; slice i = data[16*i+15:16*i].
- grant  out  N_REQ  one-hot current owner; all-zero when idle; registered.
- owner  out  IDX_W  index of current/last owner; registered.
- disp_data  out  16  data forwarded to hex_display; registered.
- disp_valid  out  1  1 = display shows disp_data; 0 = blank; registered.

Behaviour:
- Reset values (sync, active-high): grant=0, owner=0, disp_data=16'h0000, disp_valid=0, hold counter=0, expired=0, state=IDLE. The round-robin pointer is set to N_REQ-1, so requester 0 has first priority.
- Round-robin pick: scan indices ptr+1, ptr+2, … modulo N_REQ; the first asserted request wins.
- States: IDLE and HOLD.
- IDLE, edge where req!=0:
  - winner w picked from ptr.
  - Updates on that edge: grant<=onehot(w), owner<=w, ptr<=w, disp_data<=data slice w, disp_valid<=1, cnt<=0, expired<=0, state<=HOLD.
  - Latency: req sampled at edge k gives grant and valid data visible after edge k (one cycle from req assertion).
- IDLE, req==0: outputs hold; disp_valid stays 0.
- HOLD, every edge: disp_data<=data slice owner (live tracking, 1-cycle latency).
- Hold counter:
  - cnt increments each HOLD cycle.
  - When cnt reaches HOLD_TICKS-1, expired<=1 and cnt saturates.
  - Counter width clog2(HOLD_TICKS+1).
- HOLD priority order, evaluated per edge:
  1. Owner drops req: grant<=0, disp_valid<=0, state<=IDLE, ptr=owner; disp_data keeps its last value. This happens regardless of the hold timer, and no re-grant occurs in the same edge (minimum one idle cycle).
  2. Expired and (req & ~grant)!=0: switch directly to the round-robin winner among the other requesters, searched from owner+1. Grant, owner, ptr and disp_data (new slice) all update on the same edge; cnt<=0, expired<=0; disp_valid stays 1 (no blank gap).
  3. Otherwise: keep the owner. A sole requester owns the display indefinitely.
- Guarantee: a waiting requester is granted within (N_REQ-1)*HOLD_TICKS + N_REQ cycles, provided the other owners keep requesting.
- Invariants: grant is zero or one-hot; disp_valid == |grant; owner always equals the index of the set grant bit when grant!=0.
- Simultaneous requests in IDLE: lowest index after ptr, cyclically.
- Requests for the current owner's own slot never cause a switch.
- Reset mid-HOLD: all state returns to reset values on that edge; pointer restored to N_REQ-1.
- Data changes on a non-owner slice have no effect on outputs.

Test Plan:
Benches use N_REQ=4, HOLD_TICKS=4.
1. Reset: assert rst 2 cycles with req=4'b1111 -> grant=0, disp_valid=0, disp_data=16'h0000. Release rst -> after next edge grant=4'b0001, owner=0.
2. Single source: req=4'b0010, data slice1=16'hC1AC -> one edge later grant=4'b0010, disp_data=16'hC1AC, disp_valid=1. Change slice1 to 16'h1234 -> disp_data=16'h1234 one edge later; grant stays indefinitely.
3. Two sources: req0 and req2 asserted from IDLE -> grant=4'b0001 for exactly 4 cycles, then 4'b0100 for 4 cycles, alternating. disp_valid never drops; disp_data switches on the same edge as grant.
4. Owner drop mid-hold: owner 0 drops req at hold cycle 2 while req1 waits -> next edge grant=0, disp_valid=0. Following edge grant=4'b0010.
5. Full round-robin: all four req held -> grant order 0,1,2,3,0,… with each grant lasting 4 cycles; owner output matches each grant.
6. Reset mid-hold: rst pulsed while owner=2 -> grant=0, disp_valid=0. With req=4'b1111 after release, the first grant goes to 0, not 3.
